// File: rtl/pla_prog_pipe.sv
// pla_prog_pipe: run-time programmable AND/OR logic array with 2-stage valid/ready evaluation pipeline
// clk, rst_n              : clock, asynchronous active-low reset
// i_cfg_we/sel/addr/data  : plane write port (00 AND row + enable, 01 OR row, 10 disable term, 11 reserved)
// o_cfg_ready, o_cfg_err  : write acceptable (pipeline empty), 1-cycle pulse on an invalid accepted write
// i_in_valid/data, o_in_ready    : input vector stream
// o_out_valid/data, i_out_ready  : evaluated output stream
module pla_prog_pipe #(
  parameter int N_IN = 17,
  parameter int N_OUT = 69,
  parameter int N_TERMS = 64,
  localparam int CFG_W = (2 * N_IN > N_OUT) ? 2 * N_IN : N_OUT,
  localparam int AW = $clog2(N_TERMS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cfg_we,
  input  logic [1:0]       i_cfg_sel,
  input  logic [AW-1:0]    i_cfg_addr,
  input  logic [CFG_W-1:0] i_cfg_data,
  output logic             o_cfg_ready,
  output logic             o_cfg_err,
  input  logic             i_in_valid,
  input  logic [N_IN-1:0]  i_in_data,
  output logic             o_in_ready,
  output logic             o_out_valid,
  output logic [N_OUT-1:0] o_out_data,
  input  logic             i_out_ready
);
  logic [N_IN-1:0]    r_care [N_TERMS];
  logic [N_IN-1:0]    r_val  [N_TERMS];
  logic [N_OUT-1:0]   r_or   [N_TERMS];
  logic [N_TERMS-1:0] r_en;
  logic               r_s1_valid, r_s2_valid, r_err;
  logic [N_TERMS-1:0] r_s1_act;
  logic [N_OUT-1:0]   r_out;
  logic [N_TERMS-1:0] w_act;
  logic [N_OUT-1:0]   w_or;
  logic               w_adv1, w_adv2, w_cfg_go, w_bad, w_addr_bad;
  assign w_adv2      = r_s1_valid & (~r_s2_valid | i_out_ready);
  assign w_adv1      = ~r_s1_valid | w_adv2;
  assign o_in_ready  = w_adv1 & ~i_cfg_we;
  assign o_cfg_ready = ~r_s1_valid & ~r_s2_valid;
  assign w_cfg_go    = i_cfg_we & o_cfg_ready;
  assign w_bad       = w_addr_bad | (i_cfg_sel == 2'b11);
  assign o_cfg_err   = r_err;
  assign o_out_valid = r_s2_valid;
  assign o_out_data  = r_out;
  // a power-of-two capacity makes every address representable, so no range check exists
  if (N_TERMS == (1 << AW)) begin : g_pow2
    assign w_addr_bad = 1'b0;
  end else begin : g_range
    assign w_addr_bad = i_cfg_addr >= AW'(N_TERMS);
  end
  always_comb begin
    w_act = '0;
    for (int t = 0; t < N_TERMS; t++)
      w_act[t] = r_en[t] & ~|((i_in_data ^ r_val[t]) & r_care[t]);
  end
  always_comb begin
    w_or = '0;
    for (int t = 0; t < N_TERMS; t++)
      w_or = w_or | ({N_OUT{r_s1_act[t]}} & r_or[t]);
  end
  // planes only move while the pipeline is empty, so in-flight vectors see the planes they were accepted with
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int t = 0; t < N_TERMS; t++) begin
        r_care[t] <= '0;
        r_val[t]  <= '0;
        r_or[t]   <= '0;
      end
      r_en <= '0;
    end else if (w_cfg_go & ~w_bad) begin
      if (i_cfg_sel == 2'b00) begin
        r_care[i_cfg_addr] <= i_cfg_data[N_IN-1:0];
        r_val[i_cfg_addr]  <= i_cfg_data[2*N_IN-1:N_IN];
        r_en[i_cfg_addr]   <= 1'b1;
      end
      if (i_cfg_sel == 2'b01) r_or[i_cfg_addr] <= i_cfg_data[N_OUT-1:0];
      if (i_cfg_sel == 2'b10) r_en[i_cfg_addr] <= 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_act   <= '0;
      r_s2_valid <= 1'b0;
      r_out      <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= w_cfg_go & w_bad;
      if (w_adv1) begin
        r_s1_valid <= i_in_valid & o_in_ready;
        r_s1_act   <= w_act;
      end
      if (~r_s2_valid | i_out_ready) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) r_out <= w_or;
      end
    end
  end
endmodule

// File: tb/tb_pla_prog_pipe.sv
// tb_pla_prog_pipe: directed + randomized bench for pla_prog_pipe against a cube-list reference model
module tb_pla_prog_pipe;
  logic        clk = 0, rst_n = 0;
  logic        cfg_we = 0, in_valid = 0, out_ready = 1;
  logic [1:0]  cfg_sel = 0;
  logic [5:0]  cfg_addr = 0;
  logic [68:0] cfg_data = 0;
  logic [16:0] in_data = 0;
  logic        cfg_ready, cfg_err, in_ready, out_valid;
  logic [68:0] out_data;
  logic        b_we = 0;
  logic [1:0]  b_sel = 0;
  logic [5:0]  b_addr = 0;
  logic        b_cfg_ready, b_err, b_in_ready, b_out_valid;
  logic [68:0] b_out_data;
  always #5 clk = ~clk;
  pla_prog_pipe dut (
    .clk(clk), .rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_sel(cfg_sel), .i_cfg_addr(cfg_addr),
    .i_cfg_data(cfg_data), .o_cfg_ready(cfg_ready), .o_cfg_err(cfg_err), .i_in_valid(in_valid),
    .i_in_data(in_data), .o_in_ready(in_ready), .o_out_valid(out_valid), .o_out_data(out_data),
    .i_out_ready(out_ready)
  );
  pla_prog_pipe #(.N_TERMS(40)) u2 (
    .clk(clk), .rst_n(rst_n), .i_cfg_we(b_we), .i_cfg_sel(b_sel), .i_cfg_addr(b_addr),
    .i_cfg_data(69'h0), .o_cfg_ready(b_cfg_ready), .o_cfg_err(b_err), .i_in_valid(1'b0),
    .i_in_data(17'h0), .o_in_ready(b_in_ready), .o_out_valid(b_out_valid), .o_out_data(b_out_data),
    .i_out_ready(1'b1)
  );
  int n_vec = 0, n_err = 0, cyc = 0, sent;
  logic [16:0] m_care [64];
  logic [16:0] m_val  [64];
  logic [68:0] m_or   [64];
  logic        m_en   [64];
  logic [68:0] q [$];
  int          qc [$];
  logic        exp_err = 0, exp_err_b = 0, in_acc, cfg_acc;
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic timeout(input string tag);
    n_vec++;
    n_err++;
    $error("FAIL %s timeout observed=stalled expected=handshake", tag);
  endtask
  function automatic logic [68:0] eval(input logic [16:0] x);
    logic [68:0] z = '0;
    for (int t = 0; t < 64; t++)
      if (m_en[t] && ((x ^ m_val[t]) & m_care[t]) == 17'h0) z |= m_or[t];
    return z;
  endfunction
  function automatic logic [68:0] and_row(input logic [16:0] val, input logic [16:0] care);
    return {35'($urandom), val, care};
  endfunction
  task automatic clr();
    for (int t = 0; t < 64; t++) begin
      m_care[t] = 0; m_val[t] = 0; m_or[t] = 0; m_en[t] = 0;
    end
    q.delete(); qc.delete();
    exp_err = 0; exp_err_b = 0;
  endtask
  // one clock: check outputs mid-cycle against the 2-slot pipeline model, then advance the model
  task automatic tick();
    logic ev, ir, cr;
    @(negedge clk);
    in_acc = 0; cfg_acc = 0;
    ev = q.size() > 0 && cyc >= qc[0] + 2;
    cr = q.size() == 0;
    ir = !cfg_we && (q.size() < 2 || out_ready);
    chk("out_valid", out_valid, ev);
    if (ev) chk("out_data", out_data, q[0]);
    chk("cfg_ready", cfg_ready, cr);
    chk("in_ready", in_ready, ir);
    chk("cfg_err", cfg_err, exp_err);
    chk("cfg_err_b", b_err, exp_err_b);
    exp_err = 0; exp_err_b = 0;
    if (rst_n) begin
      if (ev && out_ready) begin void'(q.pop_front()); void'(qc.pop_front()); end
      if (cfg_we && cr) begin
        cfg_acc = 1;
        exp_err = cfg_sel == 2'b11;
        if (cfg_sel == 2'b00) begin
          m_care[cfg_addr] = cfg_data[16:0]; m_val[cfg_addr] = cfg_data[33:17]; m_en[cfg_addr] = 1;
        end
        if (cfg_sel == 2'b01) m_or[cfg_addr] = cfg_data;
        if (cfg_sel == 2'b10) m_en[cfg_addr] = 0;
      end
      if (in_valid && ir) begin in_acc = 1; q.push_back(eval(in_data)); qc.push_back(cyc); end
      exp_err_b = b_we && (b_addr >= 40 || b_sel == 2'b11);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic cfg(input logic [1:0] sel, input logic [5:0] addr, input logic [68:0] d);
    int k = 0;
    cfg_we = 1; cfg_sel = sel; cfg_addr = addr; cfg_data = d;
    do begin tick(); k++; end while (!cfg_acc && k < 40);
    if (!cfg_acc) timeout("cfg_write");
    cfg_we = 0;
  endtask
  task automatic send(input logic [16:0] x);
    int k = 0;
    in_valid = 1; in_data = x;
    do begin tick(); k++; end while (!in_acc && k < 40);
    if (!in_acc) timeout("send");
    in_valid = 0;
  endtask
  task automatic drain();
    int k = 0;
    out_ready = 1;
    while (q.size() > 0 && k < 40) begin tick(); k++; end
    if (q.size() > 0) timeout("drain");
    tick();
  endtask
  task automatic do_reset();
    rst_n = 0; cfg_we = 0; in_valid = 0; b_we = 0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 69'h0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);
    chk("rst_cfg_err", cfg_err, 1'b0);
    clr();
    tick(); tick();
    rst_n = 1;
  endtask
  function automatic logic [16:0] rx();
    int i = 2 + $urandom_range(0, 9);
    return ($urandom % 2) ? (m_val[i] & m_care[i]) | (17'($urandom) & ~m_care[i]) : 17'($urandom);
  endfunction
  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    // T1: unprogrammed array yields zero; reset mid-stream empties everything at once
    send(17'h1FFFF);
    drain();
    in_valid = 1;
    for (int k = 0; k < 3; k++) begin in_data = 17'($urandom); tick(); end
    do_reset();
    send(17'h1FFFF);
    drain();
    // T2: single cube
    cfg(2'b00, 0, and_row(17'h00006, 17'h0007F));
    cfg(2'b01, 0, 69'h1 << 3);
    send(17'h00006);
    send(17'h00007);
    drain();
    // T3: OR merge then disable
    cfg(2'b00, 1, and_row(17'h00000, 17'h00001));
    cfg(2'b01, 1, (69'h1 << 3) | (69'h1 << 60));
    send(17'h00006);
    drain();
    cfg(2'b10, 1, 69'h0);
    send(17'h00006);
    drain();
    // T6: reserved select and out-of-range address pulse an error and leave planes alone
    cfg(2'b11, 0, {$urandom, $urandom, 5'h1F});
    tick(); tick();
    send(17'h00006);
    drain();
    b_we = 1; b_sel = 2'b00; b_addr = 45; tick();
    b_addr = 39; b_sel = 2'b01; tick();
    b_addr = 2; b_sel = 2'b11; tick();
    b_we = 0; tick(); tick();
    // T5: config collides with input on an empty pipeline
    cfg(2'b01, 5, 69'h1 << 68);
    cfg_we = 1; cfg_sel = 2'b00; cfg_addr = 5; cfg_data = and_row(17'h10000, 17'h10000);
    in_valid = 1; in_data = 17'h10000;
    tick();
    cfg_we = 0;
    send(17'h10000);
    drain();
    out_ready = 0;
    send(17'h10000);
    tick(); tick();
    cfg_we = 1; cfg_sel = 2'b10; cfg_addr = 5;
    tick(); tick(); tick();
    out_ready = 1;
    for (int k = 0; k < 20 && !cfg_acc; k++) tick();
    if (!cfg_acc) timeout("cfg_after_drain");
    cfg_we = 0;
    send(17'h10000);
    drain();
    // random planes for the streaming phases
    for (int t = 2; t < 12; t++) begin
      cfg(2'b00, 6'(t), and_row(17'($urandom), 17'($urandom) & 17'($urandom)));
      cfg(2'b01, 6'(t), {5'($urandom), $urandom, $urandom});
    end
    // T4: 8 vectors with a 5-cycle stall mid-stream
    sent = 0; in_valid = 1; in_data = rx();
    for (int k = 0; k < 40 && sent < 8; k++) begin
      out_ready = !(k >= 3 && k < 8);
      tick();
      if (in_acc) begin sent++; in_data = rx(); end
    end
    if (sent < 8) timeout("t4_stream");
    in_valid = 0;
    drain();
    // random stream with random backpressure and a mid-stream disable
    for (int p = 0; p < 2; p++) begin
      sent = 0; in_data = rx();
      for (int k = 0; k < 3000 && sent < 150; k++) begin
        in_valid = ($urandom % 4) != 0;
        out_ready = ($urandom % 3) != 0;
        tick();
        if (in_acc) begin sent++; in_data = rx(); end
      end
      if (sent < 150) timeout("rand_stream");
      in_valid = 0;
      drain();
      cfg(2'b10, 6'($urandom_range(2, 11)), 69'h0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
